// File: rtl/esc_sched_pkg.sv
// -----------------------------------------------------------------------------
// esc_sched_pkg
// Shared definitions for the ESC frame scheduler.
//   state_t    : scheduler state (DISARMED, ARMING, RUN)
//   MOTOR_CNT  : number of motors in the bank (index 0..3 = front, back,
//                left, right)
//   SPD_W      : width of one speed word
//   spd_vec_t  : all motor speeds packed together, element i = motor i
// -----------------------------------------------------------------------------
package esc_sched_pkg;

   localparam int MOTOR_CNT = 4;
   localparam int SPD_W     = 11;

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMING   = 2'd1,
      RUN      = 2'd2
   } state_t;

   typedef logic [MOTOR_CNT-1:0][SPD_W-1:0] spd_vec_t;

endpackage

// File: rtl/esc_slew.sv
// -----------------------------------------------------------------------------
// esc_slew
// Per-motor slew limiter. Computes the next output value by moving the
// current value toward the target by at most SLEW_MAX per update.
// Ports:
//   cur  in  SPD_W  value currently driven to the ESC
//   tgt  in  SPD_W  commanded target speed
//   en   in  1      apply the step; when low the value holds
//   nxt  out SPD_W  next value (always within 0..2^SPD_W-1)
// Parameters:
//   SLEW_MAX  largest per-update change magnitude
// -----------------------------------------------------------------------------
module esc_slew
   import esc_sched_pkg::*;
#(
   parameter int SLEW_MAX = 32
) (
   input  logic [SPD_W-1:0] cur,
   input  logic [SPD_W-1:0] tgt,
   input  logic             en,
   output logic [SPD_W-1:0] nxt
);

   localparam logic signed [SPD_W:0] STEP = (SPD_W+1)'(SLEW_MAX);

   logic signed [SPD_W:0] diff;
   logic signed [SPD_W:0] step;
   logic signed [SPD_W:0] sum;

   always_comb begin
      // One extra bit makes the unsigned difference representable as signed.
      diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
      if (diff > STEP) begin
         step = STEP;
      end else if (diff < -STEP) begin
         step = -STEP;
      end else begin
         step = diff;
      end
      // The step never overshoots the target, so the sum stays in range.
      sum = $signed({1'b0, cur}) + step;
      nxt = cur;
      if (en) begin
         nxt = sum[SPD_W-1:0];
      end
   end

endmodule

// File: rtl/esc_sched.sv
// -----------------------------------------------------------------------------
// esc_sched
// Frame scheduler for the four-motor ESC bank. A free-running frame counter
// defines frames of 2^FRAME_W clocks. At each frame start the commanded
// speeds are latched (zeros unless in RUN), and each motor then receives a
// one-cycle write strobe, staggered by STAGGER clocks. A zero-throttle arming
// interval of ARM_FRAMES frame starts precedes RUN. Dropping arm zeros the
// outputs on the next clock.
//
// Optional feature macro: ESC_SLEW_EN
//   defined   : in RUN each output moves toward its command by at most
//               SLEW_MAX per frame (one esc_slew per motor).
//   undefined : outputs take the commanded speeds directly; SLEW_MAX unused.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   arm        in   level, high requests armed operation
//   frnt_spd, bck_spd, lft_spd, rght_spd   in   commanded speeds (SPD_W)
//   frnt_out, bck_out, lft_out, rght_out   out  speeds to ESCs (motor 0..3)
//   wrt        out  one-cycle write strobe per motor, bit i = motor i
//   frm_strt   out  one-cycle pulse while the frame counter reads 0
//   armed      out  high in RUN only
//
// Timing: the frame-start event is the clock edge on which the frame counter
// wraps to 0. State changes and speed latches happen on that edge, so
// frm_strt and the new speeds appear together while the counter reads 0, and
// wrt[i] follows while the counter reads 1 + i*STAGGER.
// -----------------------------------------------------------------------------
module esc_sched
   import esc_sched_pkg::*;
#(
   parameter int FRAME_W    = 20,
   parameter int STAGGER    = 16,
   parameter int ARM_FRAMES = 64,
   parameter int SLEW_MAX   = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 arm,
   input  logic [SPD_W-1:0]     frnt_spd,
   input  logic [SPD_W-1:0]     bck_spd,
   input  logic [SPD_W-1:0]     lft_spd,
   input  logic [SPD_W-1:0]     rght_spd,
   output logic [SPD_W-1:0]     frnt_out,
   output logic [SPD_W-1:0]     bck_out,
   output logic [SPD_W-1:0]     lft_out,
   output logic [SPD_W-1:0]     rght_out,
   output logic [MOTOR_CNT-1:0] wrt,
   output logic                 frm_strt,
   output logic                 armed
);

   localparam int ARM_W = $clog2(ARM_FRAMES + 1);

   // Elaboration-time parameter checks.
   if (longint'(1 + (MOTOR_CNT-1)*STAGGER) >= (longint'(1) << FRAME_W)) begin : g_bad_stagger
      $error("esc_sched: last strobe offset 1+3*STAGGER must be below 2^FRAME_W");
   end
   if (ARM_FRAMES < 1) begin : g_bad_arm
      $error("esc_sched: ARM_FRAMES must be at least 1");
   end
   if (SLEW_MAX < 0 || SLEW_MAX >= (1 << SPD_W)) begin : g_bad_slew
      $error("esc_sched: SLEW_MAX must lie within 0..2^SPD_W-1");
   end

   logic [FRAME_W-1:0]   frm_cnt;
   logic                 frm_wrap;
   state_t               state;
   state_t               state_nxt;
   logic [ARM_W-1:0]     arm_cnt;
   logic [ARM_W-1:0]     arm_cnt_nxt;
   spd_vec_t             spd_in;
   spd_vec_t             run_spd;
   spd_vec_t             spd_q;
   spd_vec_t             spd_nxt;
   logic [MOTOR_CNT-1:0] wrt_nxt;
   logic                 armed_nxt;
   logic                 latch_run;

   assign spd_in   = {rght_spd, lft_spd, bck_spd, frnt_spd};
   // Counter at its last value: the next edge is the frame start.
   assign frm_wrap = &frm_cnt;
   assign latch_run = (state == RUN) && arm && frm_wrap;

`ifdef ESC_SLEW_EN
   for (genvar i = 0; i < MOTOR_CNT; i++) begin : g_slew
      esc_slew #(
         .SLEW_MAX (SLEW_MAX)
      ) u_slew (
         .cur (spd_q[i]),
         .tgt (spd_in[i]),
         .en  (latch_run),
         .nxt (run_spd[i])
      );
   end
`else
   assign run_spd = spd_in;
`endif

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= DISARMED;
         arm_cnt <= '0;
      end else begin
         state   <= state_nxt;
         arm_cnt <= arm_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      arm_cnt_nxt = arm_cnt;
      if (!arm) begin
         // Disarm takes priority over every frame-start action.
         state_nxt   = DISARMED;
         arm_cnt_nxt = '0;
      end else if (frm_wrap) begin
         case (state)
            DISARMED: begin
               state_nxt   = ARMING;
               arm_cnt_nxt = '0;
            end
            ARMING: begin
               // arm_cnt holds the frame starts already seen in ARMING.
               if (arm_cnt == ARM_W'(ARM_FRAMES - 1)) begin
                  state_nxt   = RUN;
                  arm_cnt_nxt = '0;
               end else begin
                  arm_cnt_nxt = arm_cnt + ARM_W'(1);
               end
            end
            RUN: begin
               state_nxt = RUN;
            end
            default: begin
               state_nxt   = DISARMED;
               arm_cnt_nxt = '0;
            end
         endcase
      end
   end

   always_comb begin
      spd_nxt = spd_q;
      if (!arm) begin
         spd_nxt = '0;
      end else if (frm_wrap) begin
         // The edge that enters RUN still latches zeros.
         spd_nxt = latch_run ? run_spd : '0;
      end
      armed_nxt = (state_nxt == RUN);
      for (int i = 0; i < MOTOR_CNT; i++) begin
         // Registered decode: strobe lands while the counter reads 1+i*STAGGER.
         wrt_nxt[i] = (frm_cnt == FRAME_W'(i * STAGGER));
      end
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frm_cnt  <= '0;
         frm_strt <= 1'b0;
         wrt      <= '0;
         armed    <= 1'b0;
         spd_q    <= '0;
      end else begin
         frm_cnt  <= frm_cnt + FRAME_W'(1);
         frm_strt <= frm_wrap;
         wrt      <= wrt_nxt;
         armed    <= armed_nxt;
         spd_q    <= spd_nxt;
      end
   end

   assign frnt_out = spd_q[0];
   assign bck_out  = spd_q[1];
   assign lft_out  = spd_q[2];
   assign rght_out = spd_q[3];

endmodule

// File: tb/tb_esc_sched.sv
// -----------------------------------------------------------------------------
// tb_esc_sched
// Randomized bench for esc_sched (FRAME_W=8, STAGGER=4, ARM_FRAMES=2,
// SLEW_MAX=32). A reference model tracks the frame position, the arming
// progress and the four motor speeds from the scheduler's rules and pushes
// the expected outputs after every clock edge; a monitor on the falling edge
// pops them and compares, with strobe/frame-start events kept in their own
// queue. Honours ESC_SLEW_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_esc_sched;

   localparam int FRAME_W    = 8;
   localparam int FRAME_LEN  = 1 << FRAME_W;
   localparam int STAGGER    = 4;
   localparam int ARM_FRAMES = 2;
   localparam int SLEW_MAX   = 32;
   localparam int LVL_W      = 46;  // {event flag, armed, out3, out2, out1, out0}

   localparam int M_DIS = 0;
   localparam int M_ARMING = 1;
   localparam int M_RUN = 2;

   // ------------------------------------------------ clock / reset block
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        arm = 1'b0;
   logic [10:0] frnt_spd = '0, bck_spd = '0, lft_spd = '0, rght_spd = '0;
   logic [10:0] frnt_out, bck_out, lft_out, rght_out;
   logic [3:0]  wrt;
   logic        frm_strt;
   logic        armed;

   always #5 clk = ~clk;

   esc_sched #(
      .FRAME_W    (FRAME_W),
      .STAGGER    (STAGGER),
      .ARM_FRAMES (ARM_FRAMES),
      .SLEW_MAX   (SLEW_MAX)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .arm      (arm),
      .frnt_spd (frnt_spd),
      .bck_spd  (bck_spd),
      .lft_spd  (lft_spd),
      .rght_spd (rght_spd),
      .frnt_out (frnt_out),
      .bck_out  (bck_out),
      .lft_out  (lft_out),
      .rght_out (rght_out),
      .wrt      (wrt),
      .frm_strt (frm_strt),
      .armed    (armed)
   );

   int n_cmp = 0;
   int n_fail = 0;

   logic [LVL_W-1:0] exp_q[$];
   logic [4:0]       evt_q[$];

   // ---------------------------------------------------- reference model
   int m_pos = 0;
   int m_mode = M_DIS;
   int m_cnt = 0;
   int m_out[4] = '{0, 0, 0, 0};

   function automatic int slew_step(input int cur, input int tgt);
      int d;
      d = tgt - cur;
      if (d > SLEW_MAX) d = SLEW_MAX;
      if (d < -SLEW_MAX) d = -SLEW_MAX;
      return cur + d;
   endfunction

   always @(posedge clk) begin
      int np;
      bit st;
      logic [3:0] ew;
      int cmd[4];
      if (!rst_n) begin
         m_pos = 0;
         m_mode = M_DIS;
         m_cnt = 0;
         for (int i = 0; i < 4; i++) m_out[i] = 0;
         exp_q.push_back('0);
      end else begin
         cmd[0] = int'(frnt_spd);
         cmd[1] = int'(bck_spd);
         cmd[2] = int'(lft_spd);
         cmd[3] = int'(rght_spd);
         np = (m_pos + 1) % FRAME_LEN;
         st = (np == 0);
         for (int i = 0; i < 4; i++) ew[i] = (np == 1 + i * STAGGER);
         if (!arm) begin
            m_mode = M_DIS;
            m_cnt = 0;
            for (int i = 0; i < 4; i++) m_out[i] = 0;
         end else if (st) begin
            if (m_mode == M_DIS) begin
               m_mode = M_ARMING;
               m_cnt = 0;
               for (int i = 0; i < 4; i++) m_out[i] = 0;
            end else if (m_mode == M_ARMING) begin
               m_cnt++;
               if (m_cnt == ARM_FRAMES) m_mode = M_RUN;
               for (int i = 0; i < 4; i++) m_out[i] = 0;
            end else begin
               for (int i = 0; i < 4; i++) begin
`ifdef ESC_SLEW_EN
                  m_out[i] = slew_step(m_out[i], cmd[i]);
`else
                  m_out[i] = cmd[i];
`endif
               end
            end
         end
         m_pos = np;
         exp_q.push_back({(ew != 4'd0) || st, (m_mode == M_RUN),
                          11'(m_out[3]), 11'(m_out[2]), 11'(m_out[1]), 11'(m_out[0])});
         if ((ew != 4'd0) || st) evt_q.push_back({ew, st});
      end
   end

   // ------------------------------------------------- scoreboard monitor
   always @(negedge clk) begin
      logic [LVL_W-1:0] e;
      logic [4:0] ee;
      logic [44:0] act;
      bit dut_evt;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL lvl_queue_empty t=%0t", $time);
      end else begin
         e = exp_q.pop_front();
         act = {armed, rght_out, lft_out, bck_out, frnt_out};
         n_cmp++;
         if (act !== e[44:0]) begin
            n_fail++;
            $display("FAIL outputs t=%0t got armed=%0b spd=%0d/%0d/%0d/%0d want armed=%0b spd=%0d/%0d/%0d/%0d",
                     $time, armed, frnt_out, bck_out, lft_out, rght_out,
                     e[44], e[10:0], e[21:11], e[32:22], e[43:33]);
         end
         dut_evt = (wrt != 4'd0) || frm_strt;
         if (dut_evt || e[45]) begin
            n_cmp++;
            if (dut_evt && e[45] && evt_q.size() != 0) begin
               ee = evt_q.pop_front();
               if ({wrt, frm_strt} !== ee) begin
                  n_fail++;
                  $display("FAIL strobe t=%0t got wrt=%b frm_strt=%b want wrt=%b frm_strt=%b",
                           $time, wrt, frm_strt, ee[4:1], ee[0]);
               end
            end else if (dut_evt) begin
               n_fail++;
               $display("FAIL spurious_strobe t=%0t got wrt=%b frm_strt=%b want none",
                        $time, wrt, frm_strt);
            end else begin
               n_fail++;
               ee = (evt_q.size() != 0) ? evt_q.pop_front() : 5'd0;
               $display("FAIL missing_strobe t=%0t got none want wrt=%b frm_strt=%b",
                        $time, ee[4:1], ee[0]);
            end
         end
      end
   end

   // ------------------------------------------------------ driver tasks
   task automatic rand_speeds();
      frnt_spd = 11'($urandom_range(0, 2047));
      bck_spd  = 11'($urandom_range(0, 2047));
      lft_spd  = 11'($urandom_range(0, 2047));
      rght_spd = 11'($urandom_range(0, 2047));
   endtask

   task automatic idle(input int n, input int chg_odds);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (chg_odds > 0 && $urandom_range(0, chg_odds - 1) == 0) rand_speeds();
      end
   endtask

   // Returns at a falling edge where the DUT frame counter reads p.
   task automatic wait_pos(input int p);
      int k;
      k = 0;
      @(negedge clk);
      while (m_pos != p && k < 2 * FRAME_LEN) begin
         @(negedge clk);
         k++;
      end
      if (m_pos != p) begin
         n_cmp++;
         n_fail++;
         $display("FAIL wait_pos timeout got pos=%0d want pos=%0d", m_pos, p);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   // --------------------------------------------------------- stimulus
   initial begin
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;

      // Disarmed: strobes every frame, outputs stay 0.
      idle(2 * FRAME_LEN, 16);

      // Arm with front speed 1000: two arming frames of zeros, then RUN.
      frnt_spd = 11'd1000;
      arm = 1'b1;
      idle(5 * FRAME_LEN + 20, 0);

      // Drop arm mid-frame.
      wait_pos(100);
      arm = 1'b0;
      idle(FRAME_LEN + 40, 8);

      // Re-arm, reach RUN, then a one-cycle arm drop on the frame-start edge.
      arm = 1'b1;
      rand_speeds();
      idle(4 * FRAME_LEN, 64);
      wait_pos(FRAME_LEN - 1);
      arm = 1'b0;
      @(negedge clk);
      arm = 1'b1;
      idle(2 * FRAME_LEN, 64);

      // Slew-visible ramp: small command then back to zero.
      frnt_spd = 11'd100;
      idle(5 * FRAME_LEN, 0);
      frnt_spd = 11'd0;
      idle(5 * FRAME_LEN, 0);

      // Random arm toggling and speed changes.
      for (int k = 0; k < 20 * FRAME_LEN; k++) begin
         @(negedge clk);
         if ($urandom_range(0, 63) == 0) rand_speeds();
         if (arm && $urandom_range(0, 1499) == 0) arm = 1'b0;
         else if (!arm && $urandom_range(0, 99) == 0) arm = 1'b1;
      end

      // Asynchronous reset in RUN just after motor 1's strobe.
      arm = 1'b1;
      rand_speeds();
      idle(4 * FRAME_LEN, 0);
      wait_pos(6);
      #1 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({armed, frm_strt, wrt, frnt_out, bck_out, lft_out, rght_out} !== '0) begin
         n_fail++;
         $display("FAIL async_reset got armed=%0b wrt=%b spd=%0d/%0d/%0d/%0d want all zero",
                  armed, wrt, frnt_out, bck_out, lft_out, rght_out);
      end
      idle(12, 0);
      #1 rst_n = 1'b1;
      idle(FRAME_LEN + 20, 32);

      idle(2, 0);
      n_cmp++;
      if (evt_q.size() != 0) begin
         n_fail++;
         $display("FAIL evt_queue_drain got %0d pending want 0", evt_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/esc_sched.md
# esc_sched

Frame scheduler for the four-motor ESC bank. Generates the periodic write strobes that retrigger each ESC pulse generator, latches the four commanded speeds once per frame so all motors see a coherent set, staggers the per-motor writes, and enforces a zero-throttle arming interval before commanded speeds are passed through. Sits between the flight controller's speed outputs and the four ESC pulse-generator instances.

## Interface
- FRAME_W, 20: frame counter width; frame period = 2^FRAME_W clocks.
- STAGGER, 16: clocks between consecutive motor write strobes.
- ARM_FRAMES, 64: zero-throttle frames required in ARMING before RUN.
- SLEW_MAX, 32: max per-frame speed change per motor (used only with ESC_SLEW_EN).

- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- arm  in  1  level; high requests armed operation.
- frnt_spd, bck_spd, lft_spd, rght_spd  in  11 each  commanded speeds, unsigned.
- frnt_out, bck_out, lft_out, rght_out  out  11 each  speeds to ESCs, motor index 0..3 in this order.
- wrt  out  4  one-cycle write strobe per motor; bit i pairs with motor i.
- frm_strt  out  1  one-cycle pulse at the frame boundary.
- armed  out  1  high in RUN only.

## Operation
- Frame counter frm_cnt (FRAME_W bits) increments every clock and wraps naturally. frm_strt = (frm_cnt == 0), registered.
- States: DISARMED, ARMING, RUN.
  - DISARMED -> ARMING when arm is high at a frame start.
  - ARMING counts frame starts in arm_cnt. On the ARM_FRAMES-th frame start in ARMING, go to RUN.
  - Any state -> DISARMED on the clock where arm is low. arm_cnt clears.
- Speed latch at each frame start:
  - DISARMED/ARMING: all outputs 0.
  - RUN: outputs take the input speeds, sampled that same cycle. With ESC_SLEW_EN the slew rule applies instead.
  - Outputs hold for the entire frame.
- arm falling: all outputs go to 0 on the next clock, without waiting for a frame start. Strobes continue as scheduled, so the ESCs keep receiving minimum-width pulses.
- Strobes are issued every frame in every state. wrt[i] is high for exactly one cycle, at frm_cnt == 1 + i*STAGGER. This guarantees outputs are stable at least one cycle before each strobe.
- Simultaneous events:
  - arm low on a frame start: DISARMED wins and zeros are latched.
  - ARM_FRAMES-th frame start in ARMING: latches zeros. The first commanded speed is latched at the following frame start.
- Constraint: 1 + 3*STAGGER < 2^FRAME_W. Violation is an assertion error.

## Timing
- Reset values: every output 0, state DISARMED, frm_cnt 0, arm_cnt 0. The first frm_strt occurs after a 2^FRAME_W wrap, not at reset release.
- Reset asserted mid-frame clears all outputs immediately (asynchronous). No partial strobe sequence resumes.
- Latency:
  - Input speed to output: up to one frame, plus one clock at the frame start.
  - Output to wrt[i]: 1 + i*STAGGER clocks.
- All outputs are registered.

## Configuration
- ESC_SLEW_EN defined:
  - In RUN at each frame start: out_i <= out_i + clamp(in_i - out_i, -SLEW_MAX, +SLEW_MAX).
  - The difference is computed as a 12-bit signed value; the result is always within 0..2047.
  - Entering RUN, the ramp starts from 0.
- ESC_SLEW_EN undefined: out_i <= in_i directly. No slew logic is synthesized; SLEW_MAX is ignored.

## Structure
- Shared package esc_sched_pkg: state enum (DISARMED, ARMING, RUN), MOTOR_CNT = 4, SPD_W = 11.
- Sub-module esc_slew: one instance per motor, instantiated only under ESC_SLEW_EN. Inputs are current output, target, and enable; output is the next value.
- The top holds frm_cnt, the FSM, arm_cnt, and strobe decode.

## Test plan
Bench parameters: FRAME_W=8, STAGGER=4, ARM_FRAMES=2, SLEW_MAX=32.
- Reset release, arm=0: wrt = 0001, 0010, 0100, 1000 at frm_cnt 1, 5, 9, 13 in every frame; all outputs 0; armed=0.
- arm=1, frnt_spd=1000: first frame start -> ARMING; second and third frame starts latch 0; third -> RUN, armed=1; fourth latches frnt_out=1000 (slew off).
- In RUN, drop arm at frm_cnt=100: outputs 0 and armed=0 next clock; strobes continue at 1/5/9/13.
- arm falls exactly at frm_cnt=0: DISARMED, zeros latched, no RUN latch of input.
- ESC_SLEW_EN, RUN entry with frnt_spd=100: frnt_out = 32, 64, 96, 100 on successive frames. Then frnt_spd=0: 68, 36, 4, 0.
- Async reset at frm_cnt=6 in RUN: wrt[2:3] never pulse that frame; all outputs 0 immediately.
